// File: rtl/dice_roller_multi.sv
// Multi-die cascaded roller: internal tick divider, synchronised roll button, held result.
// Define DICE_HOLD_EN to enable the per-die hold mask; otherwise the hold port is ignored.
module dice_roller_multi #(
    parameter int unsigned FACES     = 6,
    parameter int unsigned NUM_DICE  = 2,
    parameter int unsigned DIV       = 25,
    parameter int unsigned MIN_TICKS = 3,
    localparam int unsigned DW = $clog2(FACES + 1),
    localparam int unsigned SW = $clog2(NUM_DICE * FACES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   roll_button,
    input  logic [NUM_DICE-1:0]    hold,
    output logic [NUM_DICE*DW-1:0] dice,
    output logic [SW-1:0]          sum,
    output logic                   busy,
    output logic                   result_valid
);

    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW = $clog2(MIN_TICKS + 1);

    localparam logic [TW-1:0] TickMax  = TW'(DIV - 1);
    localparam logic [CW-1:0] MinTicks = CW'(MIN_TICKS);
    localparam logic [DW-1:0] Faces    = DW'(FACES);
    localparam logic [DW-1:0] One      = DW'(1);

    typedef enum logic [1:0] {StIdle, StRolling, StDone} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic            s1_q, s2_q, s3_q;
    logic            rise;
    logic [CW-1:0]   roll_cnt_q, roll_cnt_d, roll_cnt_inc;
    logic            advance;
    logic [DW-1:0]   die_q   [NUM_DICE];
    logic [DW-1:0]   die_d   [NUM_DICE];
    logic [DW-1:0]   die_adv [NUM_DICE];
    logic [SW-1:0]   sum_q, sum_d;
    logic [NUM_DICE-1:0] hold_mask;

`ifdef DICE_HOLD_EN
    assign hold_mask = hold;
`else
    logic unused_hold;
    assign hold_mask   = '0;
    assign unused_hold = ^hold;
`endif

    // Free-running divider, independent of the roll state.
    always_comb begin
        tick       = (tick_cnt_q == TickMax);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= roll_button;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    assign roll_cnt_inc = (roll_cnt_q >= MinTicks) ? roll_cnt_q : roll_cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        roll_cnt_d = roll_cnt_q;
        advance    = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d    = StRolling;
                    roll_cnt_d = '0;
                end
            end
            StRolling: begin
                if (tick) begin
                    advance    = 1'b1;
                    roll_cnt_d = roll_cnt_inc;
                    // Keep rolling while the button is still held.
                    if (!s2_q && (roll_cnt_inc >= MinTicks)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            roll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            roll_cnt_q <= roll_cnt_d;
        end
    end

    // Odometer: a held die forwards its incoming carry as though it had wrapped.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < NUM_DICE; i++) begin
            die_adv[i] = die_q[i];
            if (!hold_mask[i] && carry) begin
                if (die_q[i] == Faces) begin
                    die_adv[i] = One;
                end else begin
                    die_adv[i] = die_q[i] + One;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            die_d[i] = advance ? die_adv[i] : die_q[i];
            sum_d    = sum_d + SW'(die_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DICE; i++) begin
                die_q[i] <= One;
            end
            sum_q <= SW'(NUM_DICE);
        end else begin
            for (int i = 0; i < NUM_DICE; i++) begin
                die_q[i] <= die_d[i];
            end
            sum_q <= sum_d;
        end
    end

    always_comb begin
        dice = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            dice[i*DW +: DW] = die_q[i];
        end
    end

    assign sum          = sum_q;
    assign busy         = (state_q == StRolling);
    assign result_valid = (state_q == StDone);

endmodule
